// File: rtl/sort_drain_pkg.sv
// Shared parameter header and state encoding for sort_drain.
// Parameter macros may be predefined on the command line; otherwise the defaults below apply.
`ifndef SORT_DRAIN_PKG_DEFS
`define SORT_DRAIN_PKG_DEFS

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ELEMENT_NUM
`define ELEMENT_NUM 8
`endif
`ifndef LOG2_ELEMENT_NUM
`define LOG2_ELEMENT_NUM 3
`endif

`define SD_ST_IDLE   3'd0
`define SD_ST_RUN    3'd1
`define SD_ST_DRAIN  3'd2
`define SD_ST_FINISH 3'd3
`define SD_ST_HOLD   3'd4

`endif

package sort_drain_pkg;

  typedef enum logic [2:0] {
    StIdle   = `SD_ST_IDLE,
    StRun    = `SD_ST_RUN,
    StDrain  = `SD_ST_DRAIN,
    StFinish = `SD_ST_FINISH,
    StHold   = `SD_ST_HOLD
  } sd_state_e;

  // States in which the output register may pull words from the buffer.
  function automatic logic is_drain_state(input sd_state_e s);
    return (s == StRun) || (s == StDrain);
  endfunction

endpackage

// File: rtl/drain_buf.sv
// N-deep word buffer for sort_drain: one synchronous write port, one asynchronous read port.
module drain_buf #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sort_drain.sv
// Captures the sorter's fixed-rate descending burst and replays it on a valid/ready stream.
// Define SORT_DRAIN_CHECK_EN to add the sticky order_err checker and port.
module sort_drain
  import sort_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = `DATA_WIDTH,
  parameter int unsigned ELEMENT_NUM      = `ELEMENT_NUM,
  parameter int unsigned LOG2_ELEMENT_NUM = `LOG2_ELEMENT_NUM
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sm_valid,
  input  logic [LOG2_ELEMENT_NUM-1:0] sm_addr,
  input  logic [DATA_WIDTH-1:0]       sm_data,
  input  logic                        sm_done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [LOG2_ELEMENT_NUM-1:0] out_rank,
  output logic                        out_last,
  output logic                        job_done,
  output logic                        abort,
  output logic                        busy
`ifdef SORT_DRAIN_CHECK_EN
  ,
  output logic                        order_err
`endif
);

  localparam int unsigned PTR_W = LOG2_ELEMENT_NUM + 1;
  localparam logic [PTR_W-1:0] N_PTR    = PTR_W'(ELEMENT_NUM);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ELEMENT_NUM - 1);

  sd_state_e r_state;

  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic                        r_out_valid;
  logic [DATA_WIDTH-1:0]       r_out_data;
  logic [LOG2_ELEMENT_NUM-1:0] r_out_rank;
  logic                        r_out_last;
  logic                        r_job_done;
  logic                        r_abort;

  logic                  w_beat;
  logic                  w_cap;
  logic                  w_load;
  logic                  w_hs;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_beat = sm_valid & ~sm_done;

  // Beats count only when starting a job or while RUN still has room.
  assign w_cap  = w_beat & ((r_state == StIdle) |
                            ((r_state == StRun) & (r_wr_ptr != N_PTR)));
  assign w_hs   = r_out_valid & out_ready;
  assign w_load = is_drain_state(r_state) & (r_rd_ptr != r_wr_ptr) &
                  (~r_out_valid | out_ready);

  drain_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (ELEMENT_NUM),
    .ADDR_WIDTH (LOG2_ELEMENT_NUM)
  ) u_buf (
    .i_clk   (clk),
    .i_we    (w_cap),
    .i_waddr (r_wr_ptr[LOG2_ELEMENT_NUM-1:0]),
    .i_wdata (sm_data),
    .i_raddr (r_rd_ptr[LOG2_ELEMENT_NUM-1:0]),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_rank  <= '0;
      r_out_last  <= 1'b0;
      r_job_done  <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_job_done <= 1'b0;
      r_abort    <= 1'b0;

      if (w_cap) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_rd_data;
        r_out_rank  <= r_rd_ptr[LOG2_ELEMENT_NUM-1:0];
        r_out_last  <= (r_rd_ptr == LAST_PTR);
        r_rd_ptr    <= r_rd_ptr + 1'b1;
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        StIdle: begin
          if (w_cap) begin
            r_state <= StRun;
          end
        end
        StRun: begin
          // A full buffer takes priority: a sorter reset right after the burst loses nothing.
          if (r_wr_ptr == N_PTR) begin
            r_state <= StDrain;
          end else if (!sm_valid) begin
            r_abort     <= 1'b1;
            r_out_valid <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_state     <= StIdle;
          end
        end
        StDrain: begin
          if (w_hs && r_out_last) begin
            r_job_done <= 1'b1;
            r_state    <= StFinish;
          end
        end
        StFinish: begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_state  <= StHold;
        end
        StHold: begin
          if (!sm_valid) begin
            r_state <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

`ifdef SORT_DRAIN_CHECK_EN
  logic [DATA_WIDTH-1:0] r_prev;
  logic                  r_order_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev      <= '0;
      r_order_err <= 1'b0;
    end else if (w_cap) begin
      if (((r_wr_ptr != '0) && (sm_data > r_prev)) ||
          (sm_addr != r_wr_ptr[LOG2_ELEMENT_NUM-1:0])) begin
        r_order_err <= 1'b1;
      end
      r_prev <= sm_data;
    end
  end

  assign order_err = r_order_err;
`else
  logic w_unused_addr;
  assign w_unused_addr = ^sm_addr;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_rank  = r_out_rank;
  assign out_last  = r_out_last;
  assign job_done  = r_job_done;
  assign abort     = r_abort;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_sort_drain.sv
// Self-checking bench for sort_drain: fixed and random descending bursts, varied consumer
// back-pressure, abort and hold behaviour, checked against a queue-based expected stream.
module tb_sort_drain;

  localparam int unsigned DW = 8;
  localparam int unsigned N  = 8;
  localparam int unsigned LW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          sm_valid;
  logic [LW-1:0] sm_addr;
  logic [DW-1:0] sm_data;
  logic          sm_done;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [LW-1:0] out_rank;
  logic          out_last;
  logic          job_done;
  logic          abort;
  logic          busy;
`ifdef SORT_DRAIN_CHECK_EN
  logic          order_err;
`endif

  sort_drain #(
    .DATA_WIDTH       (DW),
    .ELEMENT_NUM      (N),
    .LOG2_ELEMENT_NUM (LW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .sm_valid  (sm_valid),
    .sm_addr   (sm_addr),
    .sm_data   (sm_data),
    .sm_done   (sm_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rank  (out_rank),
    .out_last  (out_last),
    .job_done  (job_done),
    .abort     (abort),
    .busy      (busy)
`ifdef SORT_DRAIN_CHECK_EN
    ,
    .order_err (order_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected stream: the words of the current job in capture order.
  logic [DW-1:0] exp_q[$];
  int exp_rank;
  int hs_cnt, done_cnt, abort_cnt;
  int beat_cyc, first_valid_cyc, first_hs_cyc, last_hs_cyc;
  bit seen_valid, seen_hs, busy_exp, prev_stall;
  logic [DW-1:0] st_data;
  logic [LW-1:0] st_rank;
  logic          st_last;

  int  ready_mode = 0;
  bit  release_rdy = 1'b0;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = release_rdy;
        default: out_ready = ($urandom % 3) != 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !seen_valid) begin
        seen_valid      = 1'b1;
        first_valid_cyc = cyc;
      end
      if (prev_stall && !abort) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, st_data);
        check("stall_rank", out_rank, st_rank);
        check("stall_last", out_last, st_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", out_valid, 0);
        end else begin
          check("data", out_data, exp_q.pop_front());
          check("rank", out_rank, exp_rank);
          check("last", out_last, (exp_rank == N - 1));
        end
        exp_rank++;
        hs_cnt++;
        if (!seen_hs) first_hs_cyc = cyc;
        seen_hs     = 1'b1;
        last_hs_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      st_data    = out_data;
      st_rank    = out_rank;
      st_last    = out_last;
      if (job_done) begin
        done_cnt++;
        check("done_timing", cyc, last_hs_cyc + 1);
      end
      if (abort) begin
        abort_cnt++;
        check("abort_valid", out_valid, 0);
        exp_q.delete();
        exp_rank = 0;
      end
      if (busy_exp) check("busy", busy, 1);
    end
  end

  // One sorter job; abort_at < N drops sm_valid before that beat.
  task automatic run_job(input logic [DW-1:0] w[N], input int mode, input int abort_at);
    int t;
    seen_valid = 1'b0;
    seen_hs    = 1'b0;
    exp_rank   = 0;
    hs_cnt     = 0;
    done_cnt   = 0;
    abort_cnt  = 0;
    prev_stall = 1'b0;
    exp_q.delete();
    for (int k = 0; k < int'(N); k++) exp_q.push_back(w[k]);
    ready_mode  = mode;
    release_rdy = 1'b0;

    for (int k = 0; k < int'(N); k++) begin
      @(posedge clk);
      #1;
      if (k == 1) busy_exp = 1'b1;
      if (k == abort_at) begin
        sm_valid = 1'b0;
        busy_exp = 1'b0;
        break;
      end
      sm_valid = 1'b1;
      sm_done  = 1'b0;
      sm_addr  = LW'(k);
      sm_data  = w[k];
      if (k == 0) beat_cyc = cyc;
    end

    if (abort_at < int'(N)) begin
      repeat (3) @(negedge clk);
      check("abort_pulses", abort_cnt, 1);
      check("abort_out_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_no_done", done_cnt, 0);
      ready_mode = 0;
      return;
    end

    @(posedge clk);
    #1;
    sm_valid = 1'b1;
    sm_done  = 1'b1;
    sm_addr  = '0;
    sm_data  = DW'($urandom);

    if (mode == 2) begin
      repeat (10) @(negedge clk);
      check("stalled_no_hs", hs_cnt, 0);
      check("stalled_valid", out_valid, 1);
      @(posedge clk);
      #1;
      release_rdy = 1'b1;
    end

    t = 0;
    while (done_cnt == 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("job_done_seen", done_cnt, 1);

    repeat (20) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("words_delivered", hs_cnt, N);
    check("queue_empty", exp_q.size(), 0);
    check("hold_busy", busy, 1);
    if (mode == 0 || mode == 2) check("back_to_back", last_hs_cyc - first_hs_cyc, N - 1);
    if (mode == 0) check("latency", first_valid_cyc - beat_cyc, 2);

    @(posedge clk);
    #1;
    busy_exp = 1'b0;
    sm_valid = 1'b0;
    sm_done  = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_hold", busy, 0);
    ready_mode = 0;
  endtask

  task automatic rand_burst(output logic [DW-1:0] w[N]);
    int v;
    v = $urandom_range(128, 255);
    for (int k = 0; k < int'(N); k++) begin
      w[k] = DW'(v);
      v    = v - int'($urandom_range(0, (v < 30) ? v : 30));
    end
  endtask

  initial begin
    logic [DW-1:0] b [N];
    logic [DW-1:0] r [N];
    busy_exp = 1'b0;
    sm_valid = 1'b0;
    sm_done  = 1'b0;
    sm_addr  = '0;
    sm_data  = '0;
    rst      = 1'b0;
    #1 rst   = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst   = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_rank", out_rank, 0);
    check("rst_out_last", out_last, 0);
    check("rst_job_done", job_done, 0);
    check("rst_abort", abort, 0);
    check("rst_busy", busy, 0);
`ifdef SORT_DRAIN_CHECK_EN
    check("rst_order_err", order_err, 0);
`endif

    b = '{8'd9, 8'd7, 8'd7, 8'd5, 8'd3, 8'd2, 8'd1, 8'd0};
    run_job(b, 0, N);
    run_job(b, 1, N);
    run_job(b, 2, N);
    run_job(b, 3, 4);
    repeat (2) @(posedge clk);
    run_job(b, 0, N);
`ifdef SORT_DRAIN_CHECK_EN
    check("order_err_clean", order_err, 0);
    r = '{8'd5, 8'd6, 8'd4, 8'd3, 8'd3, 8'd2, 8'd1, 8'd0};
    run_job(r, 0, N);
    check("order_err_set", order_err, 1);
    run_job(b, 0, N);
    check("order_err_sticky", order_err, 1);
`endif

    for (int j = 0; j < 6; j++) begin
      rand_burst(r);
      run_job(r, (j % 2 == 0) ? 3 : 1, N);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
